// File: rtl/array_sched.sv
// Job sequencer for the Bit Fusion systolic array wrapper.
// Per job: latch config, strobe weight load, stream N input vectors,
// and track array latency so each psum vector is written to the
// output buffer, then pulse done.
module array_sched #(
  parameter int unsigned ARRAY_SIZE = 8,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LATENCY    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        cfg_in_width,
  input  logic [3:0]        cfg_weight_width,
  input  logic              cfg_s_in,
  input  logic              cfg_s_weight,
  input  logic [ADDR_W:0]   cfg_num_vec,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  output logic              busy,
  output logic              done,
  output logic              wt_load,
  output logic [3:0]        arr_in_width,
  output logic [3:0]        arr_weight_width,
  output logic              arr_s_in,
  output logic              arr_s_weight,
  output logic              in_rd_en,
  output logic [ADDR_W-1:0] in_rd_addr,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [LATENCY-1:0] TOP_MASK = LATENCY'(1) << (LATENCY - 1);

  // Reject parameter sets the latency tracker cannot represent.
  if (LATENCY < 1 || LATENCY > 31 || ARRAY_SIZE < 1) begin : g_param_check
    $error("array_sched: LATENCY must be 1..31 and ARRAY_SIZE >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOADW,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q;
  logic                settle_q;
  logic [CNT_W-1:0]    remain_q;
  logic                busy_q;
  logic                done_q;
  logic                wt_load_q;
  logic [3:0]          in_width_q;
  logic [3:0]          weight_width_q;
  logic                s_in_q;
  logic                s_weight_q;
  logic                in_rd_en_q;
  logic [ADDR_W-1:0]   in_rd_addr_q;
  logic [ADDR_W-1:0]   out_wr_addr_q;
  logic [LATENCY-1:0]  sr_q;
  logic [LATENCY-1:0]  sr_d;
  logic                last_wr_c;

  // Next value of the in_rd_en delay line; top bit is the psum-valid strobe.
  // last_wr_c: after this edge the only psum still in flight is the one
  // being written, so done can coincide with the final write.
  always_comb begin
    sr_d      = (sr_q << 1) | LATENCY'(in_rd_en_q);
    last_wr_c = ((sr_d & ~TOP_MASK) == '0);
  end

  // Job FSM with registered outputs and the latency delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      settle_q       <= 1'b0;
      remain_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      wt_load_q      <= 1'b0;
      in_width_q     <= '0;
      weight_width_q <= '0;
      s_in_q         <= 1'b0;
      s_weight_q     <= 1'b0;
      in_rd_en_q     <= 1'b0;
      in_rd_addr_q   <= '0;
      out_wr_addr_q  <= '0;
      sr_q           <= '0;
    end else begin
      sr_q      <= sr_d;
      wt_load_q <= 1'b0;
      done_q    <= 1'b0;
      if (sr_q[LATENCY-1]) begin
        out_wr_addr_q <= out_wr_addr_q + ADDR_W'(1);
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          if (start) begin
            state_q        <= S_LOAD;
            busy_q         <= 1'b1;
            wt_load_q      <= 1'b1;
            in_width_q     <= cfg_in_width;
            weight_width_q <= cfg_weight_width;
            s_in_q         <= cfg_s_in;
            s_weight_q     <= cfg_s_weight;
            remain_q       <= cfg_num_vec;
            in_rd_addr_q   <= cfg_in_base;
            out_wr_addr_q  <= cfg_out_base;
          end
        end

        S_LOAD: begin
          state_q  <= S_LOADW;
          settle_q <= 1'b0;
        end

        // Two cycles for weights to settle in the array.
        S_LOADW: begin
          if (!settle_q) begin
            settle_q <= 1'b1;
          end else if (remain_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q    <= S_STREAM;
            in_rd_en_q <= 1'b1;
          end
        end

        S_STREAM: begin
          remain_q <= remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            in_rd_en_q <= 1'b0;
            if (last_wr_c) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
            end
          end else begin
            in_rd_addr_q <= in_rd_addr_q + ADDR_W'(1);
          end
        end

        S_DRAIN: begin
          if (last_wr_c) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign wt_load          = wt_load_q;
  assign arr_in_width     = in_width_q;
  assign arr_weight_width = weight_width_q;
  assign arr_s_in         = s_in_q;
  assign arr_s_weight     = s_weight_q;
  assign in_rd_en         = in_rd_en_q;
  assign in_rd_addr       = in_rd_addr_q;
  assign out_wr_en        = sr_q[LATENCY-1];
  assign out_wr_addr      = out_wr_addr_q;

endmodule

// File: tb/tb_array_sched.sv
// Self-checking bench for array_sched: per-cycle expectations come from
// the job timing rules (wt_load at 1, reads at 4..3+N, writes LAT later,
// done at 3+N+LAT or 4 for empty jobs).
module tb_array_sched;

  localparam int ADDR_W = 10;
  localparam int LAT    = 12;

  logic              clk;
  logic              rst;
  logic              start;
  logic [3:0]        cfg_in_width;
  logic [3:0]        cfg_weight_width;
  logic              cfg_s_in;
  logic              cfg_s_weight;
  logic [ADDR_W:0]   cfg_num_vec;
  logic [ADDR_W-1:0] cfg_in_base;
  logic [ADDR_W-1:0] cfg_out_base;
  logic              busy;
  logic              done;
  logic              wt_load;
  logic [3:0]        arr_in_width;
  logic [3:0]        arr_weight_width;
  logic              arr_s_in;
  logic              arr_s_weight;
  logic              in_rd_en;
  logic [ADDR_W-1:0] in_rd_addr;
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_wr_addr;

  int n_checks = 0;
  int n_errors = 0;

  // Config the array should be holding while idle.
  logic [9:0] held_cfg = '0;
  logic [3:0] width_tab [3];

  array_sched #(.ARRAY_SIZE(8), .ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cfg_in_width     (cfg_in_width),
    .cfg_weight_width (cfg_weight_width),
    .cfg_s_in         (cfg_s_in),
    .cfg_s_weight     (cfg_s_weight),
    .cfg_num_vec      (cfg_num_vec),
    .cfg_in_base      (cfg_in_base),
    .cfg_out_base     (cfg_out_base),
    .busy             (busy),
    .done             (done),
    .wt_load          (wt_load),
    .arr_in_width     (arr_in_width),
    .arr_weight_width (arr_weight_width),
    .arr_s_in         (arr_s_in),
    .arr_s_weight     (arr_s_weight),
    .in_rd_en         (in_rd_en),
    .in_rd_addr       (in_rd_addr),
    .out_wr_en        (out_wr_en),
    .out_wr_addr      (out_wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [34:0] all_outs();
    return {busy, done, wt_load, in_rd_en, out_wr_en, in_rd_addr, out_wr_addr,
            arr_in_width, arr_weight_width, arr_s_in, arr_s_weight};
  endfunction

  task automatic scramble_cfg();
    cfg_in_width     = 4'($urandom);
    cfg_weight_width = 4'($urandom);
    cfg_s_in         = 1'($urandom);
    cfg_s_weight     = 1'($urandom);
    cfg_num_vec      = 11'($urandom);
    cfg_in_base      = 10'($urandom);
    cfg_out_base     = 10'($urandom);
  endtask

  // Called at a negedge (cycle 0): presents start, then checks every cycle
  // up to and including done. Returns at the done-cycle negedge so a caller
  // may chain a back-to-back job. poke_at pulses start mid-job; abort_at
  // raises rst in that cycle and stops.
  task automatic run_job(input logic [3:0] iw, input logic [3:0] ww,
                         input logic si, input logic sw, input int n,
                         input int ib, input int ob,
                         input int poke_at, input int abort_at);
    int d;
    int rd_cnt;
    int wr_cnt;
    bit aborted;
    logic [4:0] exp_ctrl;
    logic [4:0] act_ctrl;
    logic [ADDR_W-1:0] exp_addr;
    logic [9:0] job_cfg;
    d = (n == 0) ? 4 : 3 + n + LAT;
    rd_cnt = 0;
    wr_cnt = 0;
    aborted = 1'b0;
    job_cfg = {iw, ww, si, sw};
    start            = 1'b1;
    cfg_in_width     = iw;
    cfg_weight_width = ww;
    cfg_s_in         = si;
    cfg_s_weight     = sw;
    cfg_num_vec      = 11'(n);
    cfg_in_base      = 10'(ib);
    cfg_out_base     = 10'(ob);
    for (int k = 1; k <= d; k++) begin
      @(negedge clk);
      start = (k == poke_at);
      scramble_cfg();
      exp_ctrl = {k < d, k == d, k == 1,
                  n > 0 && k >= 4 && k <= 3 + n,
                  n > 0 && k >= 4 + LAT && k <= 3 + n + LAT};
      act_ctrl = {busy, done, wt_load, in_rd_en, out_wr_en};
      n_checks++;
      if (act_ctrl !== exp_ctrl) begin
        n_errors++;
        $display("FAIL ctrl n=%0d cycle %0d: busy/done/wt/rd/wr got %b want %b", n, k, act_ctrl, exp_ctrl);
      end
      if (in_rd_en === 1'b1) rd_cnt++;
      if (out_wr_en === 1'b1) wr_cnt++;
      if (exp_ctrl[1]) begin
        exp_addr = ADDR_W'(ib + k - 4);
        n_checks++;
        if (in_rd_addr !== exp_addr) begin
          n_errors++;
          $display("FAIL rd_addr cycle %0d: got %h want %h", k, in_rd_addr, exp_addr);
        end
      end
      if (exp_ctrl[0]) begin
        exp_addr = ADDR_W'(ob + k - 4 - LAT);
        n_checks++;
        if (out_wr_addr !== exp_addr) begin
          n_errors++;
          $display("FAIL wr_addr cycle %0d: got %h want %h", k, out_wr_addr, exp_addr);
        end
      end
      n_checks++;
      if ({arr_in_width, arr_weight_width, arr_s_in, arr_s_weight} !== job_cfg) begin
        n_errors++;
        $display("FAIL arr_cfg cycle %0d: got %h want %h", k,
                 {arr_in_width, arr_weight_width, arr_s_in, arr_s_weight}, job_cfg);
      end
      if (k == abort_at) begin
        rst = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      held_cfg = '0;
    end else begin
      held_cfg = job_cfg;
      n_checks++;
      if (rd_cnt != n) begin
        n_errors++;
        $display("FAIL rd_count: got %0d want %0d", rd_cnt, n);
      end
      n_checks++;
      if (wr_cnt != n) begin
        n_errors++;
        $display("FAIL wr_count: got %0d want %0d", wr_cnt, n);
      end
    end
  endtask

  // Idle cycles: no activity, config still held on the array pins.
  task automatic idle_check(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, wt_load, in_rd_en, out_wr_en} !== 5'b0 ||
          {arr_in_width, arr_weight_width, arr_s_in, arr_s_weight} !== held_cfg) begin
        n_errors++;
        $display("FAIL idle cycle %0d: ctrl %b arr %h want ctrl 00000 arr %h", k,
                 {busy, done, wt_load, in_rd_en, out_wr_en},
                 {arr_in_width, arr_weight_width, arr_s_in, arr_s_weight}, held_cfg);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    scramble_cfg();
    repeat (3) @(negedge clk);
    n_checks++;
    if (all_outs() !== 35'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    rst = 1'b0;
    held_cfg = '0;
    idle_check(2);
  endtask

  task automatic test_basic();
    run_job(4'd8, 4'd8, 1'b1, 1'b1, 4, 'h010, 'h200, 0, 0);
    idle_check(3);
  endtask

  task automatic test_zero_len();
    run_job(4'd4, 4'd2, 1'b0, 1'b1, 0, 'h055, 'h0AA, 0, 0);
    idle_check(2);
  endtask

  task automatic test_wrap();
    run_job(4'd2, 4'd8, 1'b1, 1'b0, 3, 'h3FE, 'h3FF, 0, 0);
    idle_check(2);
    run_job(4'd8, 4'd4, 1'b0, 1'b0, 1024, 'h155, 'h2AA, 0, 0);
    idle_check(2);
  endtask

  task automatic test_busy_start();
    run_job(4'd4, 4'd4, 1'b1, 1'b0, 10, 'h100, 'h300, 6, 0);
    idle_check(1);
    run_job(4'd2, 4'd2, 1'b0, 1'b1, 5, 'h020, 'h040, 15, 0);
    idle_check(1);
  endtask

  task automatic test_back_to_back();
    run_job(4'd8, 4'd8, 1'b1, 1'b1, 3, 'h001, 'h002, 0, 0);
    run_job(4'd2, 4'd4, 1'b0, 1'b1, 2, 'h3FF, 'h123, 0, 0);
    run_job(4'd4, 4'd8, 1'b1, 1'b0, 0, 'h000, 'h000, 0, 0);
    idle_check(2);
  endtask

  task automatic test_reset_mid_job();
    // Writes land at cycles 16..20; rst seen at the edge into cycle 18.
    run_job(4'd4, 4'd8, 1'b0, 1'b1, 5, 'h123, 'h0F0, 0, 17);
    @(negedge clk);
    n_checks++;
    if (all_outs() !== 35'b0) begin
      n_errors++;
      $display("FAIL reset_mid_job: got %h want 0", all_outs());
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (all_outs() !== 35'b0) begin
        n_errors++;
        $display("FAIL post_reset cycle %0d: got %h want 0", k, all_outs());
      end
    end
    run_job(4'd8, 4'd2, 1'b1, 1'b0, 2, 'h003, 'h007, 0, 0);
    idle_check(2);
  endtask

  task automatic test_random();
    int n;
    int d;
    int poke;
    for (int j = 0; j < 10; j++) begin
      n = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 40));
      d = (n == 0) ? 4 : 3 + n + LAT;
      poke = $urandom_range(0, 1) ? int'($urandom_range(2, d - 1)) : 0;
      run_job(width_tab[$urandom_range(0, 2)], width_tab[$urandom_range(0, 2)],
              1'($urandom), 1'($urandom), n,
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), poke, 0);
      if ($urandom_range(0, 1) == 1) idle_check(int'($urandom_range(1, 3)));
    end
    idle_check(2);
  endtask

  initial begin
    width_tab[0] = 4'd2;
    width_tab[1] = 4'd4;
    width_tab[2] = 4'd8;
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_busy_start();
    test_back_to_back();
    test_reset_mid_job();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
